// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: sequencer between the multicycle control unit and the
// multiply/divide units. It launches one unit per command, waits for that
// unit's done level, and commits the 64-bit result into the architectural
// HI/LO registers. It also handles mthi/mtlo writes, divide-by-zero
// detection and a wait timeout.
module muldiv_hilo_ctrl #(
   parameter int TIMEOUT = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        op_start,
   input  logic        op_sel,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        mthi_we,
   input  logic        mtlo_we,
   input  logic [31:0] wr_data,
   output logic [31:0] unit_a,
   output logic [31:0] unit_b,
   output logic        mult_start,
   input  logic        mult_done,
   input  logic [31:0] mult_hi,
   input  logic [31:0] mult_lo,
   output logic        div_start,
   input  logic        div_done,
   input  logic [31:0] div_hi,
   input  logic [31:0] div_lo,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic        timeout_err
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LastWait = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, COMMIT} state_t;

   state_t      state_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [31:0] unitA_q;
   logic [31:0] unitB_q;
   logic        opSel_q;
   logic [CW-1:0] waitCnt_q;
   logic        multStart_q;
   logic        divStart_q;
   logic        busy_q;
   logic        done_q;
   logic        divZero_q;
   logic        timeoutErr_q;

   logic        selDone;
   logic [31:0] selHi;
   logic [31:0] selLo;

   // Only the unit picked by the latched op_sel is listened to; the other
   // unit's done level and result are ignored entirely.
   always_comb begin
      selDone = mult_done;
      selHi   = mult_hi;
      selLo   = mult_lo;
      if (opSel_q) begin
         selDone = div_done;
         selHi   = div_hi;
         selLo   = div_lo;
      end
   end

   // Sequencer, HI/LO file and all registered outputs. Start and done are
   // pulses, so they default low every cycle and are raised only on the
   // transition that owns them. Done levels are never looked at in LAUNCH
   // because a unit clears its stale done on the same edge it samples start.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         hi_q         <= '0;
         lo_q         <= '0;
         unitA_q      <= '0;
         unitB_q      <= '0;
         opSel_q      <= 1'b0;
         waitCnt_q    <= '0;
         multStart_q  <= 1'b0;
         divStart_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         divZero_q    <= 1'b0;
         timeoutErr_q <= 1'b0;
      end else begin
         multStart_q <= 1'b0;
         divStart_q  <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (mthi_we) begin
                  hi_q <= wr_data;
               end
               if (mtlo_we) begin
                  lo_q <= wr_data;
               end
               if (op_start) begin
                  unitA_q      <= src_a;
                  unitB_q      <= src_b;
                  opSel_q      <= op_sel;
                  divZero_q    <= 1'b0;
                  timeoutErr_q <= 1'b0;
                  waitCnt_q    <= '0;
                  busy_q       <= 1'b1;
                  if (op_sel && (src_b == 32'd0)) begin
                     divZero_q <= 1'b1;
                     done_q    <= 1'b1;
                     state_q   <= COMMIT;
                  end else begin
                     multStart_q <= ~op_sel;
                     divStart_q  <= op_sel;
                     state_q     <= LAUNCH;
                  end
               end
            end
            LAUNCH: begin
               state_q <= WAIT;
            end
            WAIT: begin
               if (selDone) begin
                  hi_q    <= selHi;
                  lo_q    <= selLo;
                  done_q  <= 1'b1;
                  state_q <= COMMIT;
               end else if (waitCnt_q == LastWait) begin
                  timeoutErr_q <= 1'b1;
                  done_q       <= 1'b1;
                  state_q      <= COMMIT;
               end else begin
                  waitCnt_q <= waitCnt_q + 1'b1;
               end
            end
            COMMIT: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign unit_a      = unitA_q;
   assign unit_b      = unitB_q;
   assign mult_start  = multStart_q;
   assign div_start   = divStart_q;
   assign hi_out      = hi_q;
   assign lo_out      = lo_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_zero    = divZero_q;
   assign timeout_err = timeoutErr_q;

endmodule

// File: doc/muldiv_hilo_ctrl.md
# muldiv_hilo_ctrl

Sequencer and HI/LO register file between the multicycle control unit and the multiply/divide datapath units. It accepts a mult/div command with operands and pulses the selected unit's start input. It waits for the unit's done level, then commits the 64-bit result into the architectural HI/LO registers and handshakes completion back to the control unit. It also services mthi/mtlo writes and detects divide-by-zero and unit timeouts.

## Interface
- TIMEOUT, 64: maximum WAIT cycles before aborting; must be greater than 33.
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- op_start  in  1  one-cycle command pulse from control unit
- op_sel  in  1  0 = mult, 1 = div
- src_a  in  32  operand A (multiplicand / dividend)
- src_b  in  32  operand B (multiplier / divisor)
- mthi_we  in  1  write wr_data into HI
- mtlo_we  in  1  write wr_data into LO
- wr_data  in  32  mthi/mtlo data
- unit_a  out  32  registered operand A to both units
- unit_b  out  32  registered operand B to both units
- mult_start  out  1  start pulse to multiplier
- mult_done  in  1  multiplier done level (cleared by unit on start)
- mult_hi, mult_lo  in  32 each  multiplier result
- div_start  out  1  start pulse to divider
- div_done  in  1  divider done level
- div_hi, div_lo  in  32 each  remainder / quotient
- hi_out, lo_out  out  32 each  architectural HI/LO (mfhi/mflo source)
- busy  out  1  high from the cycle after op_start is accepted until the FSM returns to IDLE
- done  out  1  one-cycle completion pulse
- div_zero  out  1  sticky; set on div with src_b == 0, cleared on next accepted op_start
- timeout_err  out  1  sticky; set on WAIT expiry, cleared on next accepted op_start

## Operation
- States: IDLE, LAUNCH, WAIT, COMMIT.
- IDLE: on op_start, latch src_a/src_b into unit_a/unit_b, latch op_sel, clear div_zero and timeout_err, clear the wait counter.
  - div with src_b == 0: set div_zero, go to COMMIT without launching or writing HI/LO.
  - Otherwise go to LAUNCH.
- LAUNCH: assert mult_start or div_start (per latched op_sel) for exactly this one cycle; go to WAIT.
- WAIT: sample only the selected unit's done; the other is ignored. The wait counter increments each cycle.
  - Done high: capture {hi, lo} from that unit into the HI/LO registers; go to COMMIT.
  - Counter reaches TIMEOUT-1 without done: set timeout_err, HI/LO unchanged, go to COMMIT.
- COMMIT: done = 1 for one cycle; go to IDLE.
- unit_a/unit_b hold their values from acceptance until the next accepted op_start.
- mthi_we/mtlo_we act only in IDLE and are ignored while busy; the control unit stalls on busy.
- mthi_we/mtlo_we together in the same IDLE cycle as op_start: the write takes effect, then the operation runs and its result later overwrites HI/LO.
- op_start while busy: ignored, not queued.
- hi_out/lo_out are direct register outputs; they change only on a commit, an mthi/mtlo write, or reset.

## Timing
- Reset (synchronous, takes priority over all else): state IDLE; HI = LO = 0; unit_a = unit_b = 0; mult_start = div_start = busy = done = div_zero = timeout_err = 0. Reset mid-operation aborts with no commit.
- Edge E0 samples op_start. Cycle after E0 is LAUNCH, with start = 1 and busy = 1. Edge E1 is when the unit samples start.
- Multiplier asserts mult_done at E1+32 = E33. COMMIT captures at E34, and hi_out/lo_out show the new value from E34. done is high in the cycle after E34 and busy drops at E35.
- Multiply command-to-result latency: 34 edges. Minimum spacing between accepted op_starts: 36 edges.
- Done levels are never sampled in LAUNCH, because the unit clears a stale done on the same edge it samples start.
- Divide-by-zero: accepted at E0, COMMIT cycle follows, done is high in the cycle after E0, no start pulse is issued.

## Test plan
- Reset, then mult with src_a = 7, src_b = −3 -> mult_start pulses once at cycle after E0; at E34 hi_out = 0xFFFFFFFF, lo_out = 0xFFFFFFEB; one done pulse; busy high for exactly E0..E35.
- mult 0x80000000 × 0x80000000 -> hi_out = 0x40000000, lo_out = 0x00000000; the stale mult_done level before WAIT is not captured early.
- div with src_b = 0 -> div_zero = 1, done pulses in the cycle after E0, div_start never asserted, HI/LO unchanged; the next op_start clears div_zero.
- Div unit stub never asserting div_done, TIMEOUT = 64 -> timeout_err = 1 after 64 WAIT cycles, one done pulse, HI/LO unchanged.
- mthi_we with wr_data = 0x12345678 in IDLE -> hi_out = 0x12345678 next edge; mtlo_we and a second op_start during busy -> both ignored, result unaffected.
- reset asserted at the 10th WAIT cycle -> next edge all outputs at reset values, no done pulse; a following mult 5 × 6 gives lo_out = 30, hi_out = 0.
